// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between CPU and program loader.
// Optional LDR_LOCK_EN adds ldr_lock to hold the port across loader bursts.
module ram_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
`ifdef LDR_LOCK_EN
  input  logic              ldr_lock,
`endif
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [SW-1:0]     r_starve;
  logic [CW-1:0]     r_wcnt;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ldr_rdata;
  logic              w_idle;
  logic              w_full;
  logic              w_lock_hit;
  logic              w_gnt_ldr;
  logic              w_gnt_cpu;
  logic              w_wlast;
  logic              w_cap;

`ifdef LDR_LOCK_EN
  logic r_lock;

  // remember a locked loader burst for the following IDLE cycle
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) r_lock <= 1'b0;
    else        r_lock <= (r_state == S_DONE) & r_owner & ldr_lock & ldr_req;
  end

  assign w_lock_hit = r_lock & ldr_req;
`else
  assign w_lock_hit = 1'b0;
`endif

  assign w_idle    = (r_state == S_IDLE);
  assign w_full    = (r_starve == SW'(STARVE_MAX));
  assign w_gnt_ldr = w_idle & ldr_req & (~cpu_req | w_full | w_lock_hit);
  assign w_gnt_cpu = w_idle & cpu_req & ~w_gnt_ldr;
  assign w_wlast   = (r_wcnt == LAST);
  assign w_cap     = ~r_we & (((r_state == S_ACCESS) & (RD_LAT == 1))
                            | ((r_state == S_WAIT) & w_wlast));

  // state register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_gnt_ldr | w_gnt_cpu) w_next = S_ACCESS;
      S_ACCESS: w_next = (r_we || RD_LAT == 1) ? S_DONE : S_WAIT;
      S_WAIT:   if (w_wlast) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // latch the granted transfer
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_gnt_ldr) begin
      r_owner <= 1'b1;
      r_we    <= ldr_we;
      r_addr  <= ldr_addr;
      r_wdata <= ldr_wdata;
    end else if (w_gnt_cpu) begin
      r_owner <= 1'b0;
      r_we    <= cpu_we;
      r_addr  <= cpu_addr;
      r_wdata <= cpu_wdata;
    end
  end

  // read latency counter, running only in WAIT
  always_ff @(posedge clk or negedge clear) begin
    if (!clear)                 r_wcnt <= '0;
    else if (r_state == S_WAIT) r_wcnt <= r_wcnt + 1'b1;
    else                        r_wcnt <= '0;
  end

  // loader starvation counter, frozen while the loader holds the port
  always_ff @(posedge clk or negedge clear) begin
    if (!clear)
      r_starve <= '0;
    else if (!ldr_req || w_gnt_ldr)
      r_starve <= '0;
    else if (!(r_owner && !w_idle) && !w_full)
      r_starve <= r_starve + 1'b1;
  end

  // capture read data into the owner's holding register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
    end else if (w_cap) begin
      if (r_owner) r_ldr_rdata <= ram_rdata;
      else         r_cpu_rdata <= ram_rdata;
    end
  end

  assign ram_ce    = (r_state == S_ACCESS);
  assign ram_we    = ram_ce & r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign cpu_ack   = (r_state == S_DONE) & ~r_owner;
  assign ldr_ack   = (r_state == S_DONE) & r_owner;
  assign cpu_rdata = r_cpu_rdata;
  assign ldr_rdata = r_ldr_rdata;
  assign cpu_stall = clear & cpu_req & ~cpu_ack;
  assign busy      = ~w_idle;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scoreboard bench for ram_port_arbiter.
// Build with LDR_LOCK_EN to exercise the locked loader burst.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       clear;
  logic       cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       ldr_req, ldr_we, ldr_ack;
  logic [7:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic       ram_ce, ram_we, busy;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
`ifdef LDR_LOCK_EN
  logic       ldr_lock;
`endif

  logic       c3_req, c3_we, c3_ack, c3_stall, c3_lack;
  logic       c3_ce, c3_rwe, c3_busy;
  logic [7:0] c3_addr, c3_wdata, c3_rdata, c3_lrdata;
  logic [7:0] c3_raddr, c3_rwdata, c3_rrdata;

  logic [7:0] mem   [256];
  logic [7:0] model [256];
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;
  logic       prev_ce = 1'b0;
  string      seq;
  string      want;

  logic [37:0] outs, outs3;
  assign outs  = {cpu_ack, cpu_rdata, cpu_stall, ldr_ack, ldr_rdata,
                  ram_ce, ram_we, ram_addr, ram_wdata, busy};
  assign outs3 = {c3_ack, c3_rdata, c3_stall, c3_lack, c3_lrdata,
                  c3_ce, c3_rwe, c3_raddr, c3_rwdata, c3_busy};

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  assign c3_rrdata = mem[c3_raddr];

  always @(posedge clk) begin
    if (ram_ce && ram_we) mem[ram_addr] = ram_wdata;
  end

  ram_port_arbiter u_dut (
    .clk(clk), .clear(clear),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata),
`ifdef LDR_LOCK_EN
    .ldr_lock(ldr_lock),
`endif
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  ram_port_arbiter #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .clear(clear),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr),
    .cpu_wdata(c3_wdata), .cpu_ack(c3_ack), .cpu_rdata(c3_rdata),
    .cpu_stall(c3_stall),
    .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(8'h00),
    .ldr_wdata(8'h00),
`ifdef LDR_LOCK_EN
    .ldr_lock(1'b0),
`endif
    .ldr_ack(c3_lack), .ldr_rdata(c3_lrdata),
    .ram_ce(c3_ce), .ram_we(c3_rwe), .ram_addr(c3_raddr),
    .ram_wdata(c3_rwdata), .ram_rdata(c3_rrdata), .busy(c3_busy)
  );

  // continuous invariants on the main instance
  always @(negedge clk) begin
    if (clear === 1'b1) begin
      checks++;
      assert (!(cpu_ack && ldr_ack)) else begin
        errors++;
        $error("FAIL both_acks obs=%0b%0b exp=0", cpu_ack, ldr_ack);
      end
      checks++;
      assert (!(ram_ce && prev_ce)) else begin
        errors++;
        $error("FAIL ce_twice obs=1 exp=0");
      end
    end
    prev_ce = ram_ce;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // one transfer on one port; starts and ends just after a rising edge
  task automatic xfer(input bit ldr, input logic we, input logic [7:0] a,
                      input logic [7:0] d, input string tag);
    int n;
    logic ack;
    logic [7:0] rd;
    if (ldr) begin
      ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    end
    if (we) model[a] = d;
    else exp_q.push_back(model[a]);
    n = 0;
    @(negedge clk);
    ack = ldr ? ldr_ack : cpu_ack;
    while (!ack && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, "_ce"}, 64'(ram_ce), 64'd1);
        chk({tag, "_we"}, 64'(ram_we), 64'(we));
      end
      ack = ldr ? ldr_ack : cpu_ack;
    end
    chk({tag, "_lat"}, 64'(n), 64'd2);
    rd = ldr ? ldr_rdata : cpu_rdata;
    if (!we && ack) chk({tag, "_rd"}, 64'(rd), 64'(exp_q.pop_front()));
    @(posedge clk); #1;
    if (ldr) ldr_req = 1'b0;
    else     cpu_req = 1'b0;
    if (!we && ack) begin
      @(negedge clk);
      chk({tag, "_hold"}, 64'(ldr ? ldr_rdata : cpu_rdata), 64'(rd));
      @(posedge clk); #1;
    end
    exp_q.delete();
  endtask

  // both ports requesting: CPU rereads ca, loader writes ascending
  task automatic run_both(input int nacks, input logic [7:0] ca,
                          output string s);
    int n, cyc;
    logic adv_c, adv_l;
    s = ""; n = 0; cyc = 0;
    while (n < nacks && cyc < 200) begin
      @(negedge clk);
      cyc++;
      adv_c = cpu_ack;
      adv_l = ldr_ack;
      if (cpu_ack) begin
        s = {s, "C"};
        n++;
        chk("both_crd", 64'(cpu_rdata), 64'(exp_q.pop_front()));
      end
      if (ldr_ack) begin
        s = {s, "L"};
        n++;
        model[ldr_addr] = ldr_wdata;
        chk("both_starve", 64'(u_dut.r_starve), 64'd0);
      end
      @(posedge clk); #1;
      if (adv_c) exp_q.push_back(model[ca]);
      if (adv_l && n < nacks) begin
        ldr_addr  = ldr_addr + 8'd1;
        ldr_wdata = ldr_wdata + 8'd1;
      end
    end
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    exp_q.delete();
    chk("both_count", 64'(n), 64'(nacks));
  endtask

  initial begin
    int k, cyc;
    logic prev;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'(i * 7 + 3);
      model[i] = 8'(i * 7 + 3);
    end
    mem[8'h05] = 8'hA7; model[8'h05] = 8'hA7;
    mem[8'hFF] = 8'h81; model[8'hFF] = 8'h81;
    clear = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    c3_req = 0; c3_we = 0; c3_addr = 0; c3_wdata = 0;
`ifdef LDR_LOCK_EN
    ldr_lock = 1'b0;
`endif

    @(negedge clk);
    chk("rst_outs", 64'(outs), 64'd0);
    chk("rst_outs3", 64'(outs3), 64'd0);
    chk("rst_starve", 64'(u_dut.r_starve), 64'd0);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;

    // reset during a CPU read
    cpu_we = 0; cpu_addr = 8'h05; cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t1_access", 64'(ram_ce), 64'd1);
    #1 clear = 1'b0;
    #1 chk("t1_rst_outs", 64'(outs), 64'd0);
    @(negedge clk);
    chk("t1_rst_ack", 64'(cpu_ack), 64'd0);
    @(negedge clk);
    chk("t1_rst_hold", 64'(outs), 64'd0);
    @(posedge clk); #1;
    clear = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 1'b0, 8'h05, 8'h00, "t1_rd");

    // loader write then CPU read of the same word
    xfer(1'b1, 1'b1, 8'h10, 8'h3C, "t2_lw");
    xfer(1'b0, 1'b0, 8'h10, 8'h00, "t2_cr");

    // both requesting from a simultaneous start
    cpu_we = 0; cpu_addr = 8'h20;
    exp_q.push_back(model[8'h20]);
    ldr_we = 1; ldr_addr = 8'h40; ldr_wdata = 8'h60;
    cpu_req = 1'b1; ldr_req = 1'b1;
    run_both(9, 8'h20, seq);
    checks++;
    assert (seq == "CCLCCLCCL") else begin
      errors++;
      $error("FAIL starve_seq obs=%s exp=CCLCCLCCL", seq);
    end
    @(posedge clk); #1;

    // loader burst with CPU held high
    ldr_we = 1; ldr_addr = 8'h00; ldr_wdata = 8'h50; ldr_req = 1'b1;
`ifdef LDR_LOCK_EN
    ldr_lock = 1'b1;
    want = "LLLLLLLL";
`else
    want = "LCCLCCLC";
`endif
    @(posedge clk); #1;
    cpu_we = 0; cpu_addr = 8'h30; cpu_req = 1'b1;
    exp_q.push_back(model[8'h30]);
    run_both(8, 8'h30, seq);
    checks++;
    assert (seq == want) else begin
      errors++;
      $error("FAIL burst_seq obs=%s exp=%s", seq, want);
    end
`ifdef LDR_LOCK_EN
    ldr_lock = 1'b0;
`endif
    @(posedge clk); #1;

    // back-to-back CPU reads with request held
    cpu_we = 0; cpu_addr = 8'h00; cpu_req = 1'b1;
    exp_q.push_back(model[0]);
    k = 0; cyc = -1; prev = 1'b0;
    while (k < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (prev) chk("b2b_gap", 64'(busy), 64'd0);
      prev = cpu_ack;
      if (cpu_ack) begin
        chk("b2b_rd", 64'(cpu_rdata), 64'(exp_q.pop_front()));
        chk("b2b_cyc", 64'(cyc), 64'(2 + 3 * k));
        k++;
        @(posedge clk); #1;
        if (k < 4) begin
          cpu_addr = 8'(k);
          exp_q.push_back(model[k]);
        end else begin
          cpu_req = 1'b0;
        end
      end
    end
    chk("b2b_count", 64'(k), 64'd4);
    exp_q.delete();
    @(posedge clk); #1;

    // RD_LAT=3 read on the second instance
    c3_we = 0; c3_addr = 8'hFF; c3_req = 1'b1;
    exp_q.push_back(model[8'hFF]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("l3_stall", 64'(c3_stall), 64'(c < 4));
      chk("l3_ack", 64'(c3_ack), 64'(c == 4));
      chk("l3_ce", 64'(c3_ce), 64'(c == 1));
      if (c == 4) chk("l3_rd", 64'(c3_rdata), 64'(exp_q.pop_front()));
    end
    @(posedge clk); #1;
    c3_req = 1'b0;
    @(negedge clk);
    chk("l3_idle", 64'(c3_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
